// File: rtl/ar_tag_map_pkg.sv
// ar_tag_pkg: shared constants and types for the AR unique-ID tag map.
// Holds the FSM state encoding, the default ID/table widths and the
// tag entry record layout.
package ar_tag_pkg;

  localparam int ID_WIDTH_DEF = 4;
  localparam int NUM_TAGS_DEF = 16;

  // Allocation FSM: idle waiting for a request, or holding a grant.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // One tag table entry at the default ID width.
  typedef struct packed {
    logic                    busy;
    logic [ID_WIDTH_DEF-1:0] orig_id;
  } tag_entry_t;

endpackage

// File: rtl/ar_tag_map_if.sv
// ar_tag_map_if: allocation, free and lookup signals between the AR
// ordering stage / R path (master) and the tag map (slave).
interface ar_tag_map_if #(
  parameter int ID_WIDTH = 4
);

  logic                alloc_req;
  logic [ID_WIDTH-1:0] alloc_in_id;
  logic                alloc_gnt;
  logic [ID_WIDTH-1:0] unique_id;
  logic                tag_map_full;
  logic                free_valid;
  logic [ID_WIDTH-1:0] free_uid;
  logic [ID_WIDTH-1:0] lookup_uid;
  logic [ID_WIDTH-1:0] lookup_orig_id;

  modport master (
    output alloc_req, alloc_in_id, free_valid, free_uid, lookup_uid,
    input  alloc_gnt, unique_id, tag_map_full, lookup_orig_id
  );

  modport slave (
    input  alloc_req, alloc_in_id, free_valid, free_uid, lookup_uid,
    output alloc_gnt, unique_id, tag_map_full, lookup_orig_id
  );

endinterface

// File: rtl/ar_tag_map_prio_enc.sv
// ar_tag_prio_enc: finds the lowest-indexed zero bit in a busy vector.
// found is low when every bit is set; idx is then 0.
module ar_tag_prio_enc #(
  parameter int NUM_TAGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic [NUM_TAGS-1:0] busy,
  output logic [IDX_W-1:0]    idx,
  output logic                found
);

  // Scan from the top down so the lowest free index wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/ar_tag_map.sv
// ar_tag_map: unique-ID allocator and tag table for the AR ordering stage.
// Hands out the lowest free unique ID per request, records the original
// ARID, frees entries on RLAST retirement and offers a combinational
// reverse lookup for the R path.
// Optional build macro AR_TAG_MAP_ERR_EN enables the sticky illegal-free
// flag err_free; without it err_free is tied low.
module ar_tag_map
  import ar_tag_pkg::*;
#(
  parameter  int ID_WIDTH = ID_WIDTH_DEF,
  parameter  int NUM_TAGS = NUM_TAGS_DEF,
  localparam int CNT_W    = $clog2(NUM_TAGS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  ar_tag_map_if.slave      bus,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic             err_free
);

  state_e              state_r;
  logic [ID_WIDTH-1:0] uid_r;
  logic [NUM_TAGS-1:0] busy_r;
  logic [ID_WIDTH-1:0] orig_r [NUM_TAGS];
  logic [CNT_W-1:0]    cnt_r;

  logic [ID_WIDTH-1:0] enc_idx_s;
  logic                enc_found_s;
  logic                alloc_fire_s;
  logic [NUM_TAGS-1:0] alloc_set_s;
  logic [NUM_TAGS-1:0] free_clr_s;
  logic                free_hit_s;
  logic [ID_WIDTH-1:0] lookup_s;

  // Lowest free entry, taken from registered busy state only.
  ar_tag_prio_enc #(
    .NUM_TAGS (NUM_TAGS),
    .IDX_W    (ID_WIDTH)
  ) u_prio_enc (
    .busy  (busy_r),
    .idx   (enc_idx_s),
    .found (enc_found_s)
  );

  // A new allocation happens only from idle with a free entry available.
  assign alloc_fire_s = (state_r == ST_IDLE) && bus.alloc_req && enc_found_s;

  // One-hot set/clear vectors; a free only counts when its entry is busy,
  // which also rejects out-of-range unique IDs.
  always_comb begin
    alloc_set_s = '0;
    free_clr_s  = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      alloc_set_s[i] = alloc_fire_s && (enc_idx_s == ID_WIDTH'(i));
      free_clr_s[i]  = bus.free_valid && (bus.free_uid == ID_WIDTH'(i)) && busy_r[i];
    end
    free_hit_s = |free_clr_s;
  end

  // Reverse lookup; unique IDs beyond the table translate to 0.
  always_comb begin
    lookup_s = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      lookup_s = (bus.lookup_uid == ID_WIDTH'(i)) ? orig_r[i] : lookup_s;
    end
  end

  // Allocation FSM: capture the chosen index, hold it until req drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      uid_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (alloc_fire_s) begin
            uid_r   <= enc_idx_s;
            state_r <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!bus.alloc_req) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag table and outstanding counter; alloc and free never hit one index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
      cnt_r  <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        orig_r[i] <= '0;
      end
    end else begin
      busy_r <= (busy_r & ~free_clr_s) | alloc_set_s;
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (alloc_set_s[i]) begin
          orig_r[i] <= bus.alloc_in_id;
        end
      end
      case ({alloc_fire_s, free_hit_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

`ifdef AR_TAG_MAP_ERR_EN
  logic err_r;

  // Sticky flag for any free that did not retire a busy entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (bus.free_valid && !free_hit_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_free = err_r;
`else
  assign err_free = 1'b0;
`endif

  assign bus.alloc_gnt      = (state_r == ST_GRANT) && bus.alloc_req;
  assign bus.unique_id      = uid_r;
  assign bus.tag_map_full   = &busy_r;
  assign bus.lookup_orig_id = lookup_s;
  assign outstanding_cnt    = cnt_r;

endmodule

// File: tb/tb_ar_tag_map.sv
// tb_ar_tag_map: directed self-checking bench for ar_tag_map.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_ar_tag_map;

  localparam int ID_WIDTH = 4;
  localparam int NUM_TAGS = 16;
  localparam int CNT_W    = 5;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] outstanding_cnt;
  logic             err_free;

  int total;
  int bad;

  ar_tag_map_if #(.ID_WIDTH(ID_WIDTH)) bus ();

  ar_tag_map #(
    .ID_WIDTH (ID_WIDTH),
    .NUM_TAGS (NUM_TAGS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .outstanding_cnt (outstanding_cnt),
    .err_free        (err_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    bus.alloc_req   = 1'b0;
    bus.alloc_in_id = 4'h0;
    bus.free_valid  = 1'b0;
    bus.free_uid    = 4'h0;
    bus.lookup_uid  = 4'h0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // Raise req, wait (bounded) for a grant, check its unique ID, drop req.
  task automatic do_alloc(input logic [3:0] id, input logic [3:0] exp_uid, input string name);
    bit got;
    got = 1'b0;
    bus.alloc_req   = 1'b1;
    bus.alloc_in_id = id;
    for (int c = 0; c < 6 && !got; c++) begin
      tick();
      if (bus.alloc_gnt === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s: no grant within 6 cycles (uid required %0d)", name, exp_uid);
    end else if (bus.unique_id !== exp_uid) begin
      bad++;
      $display("FAIL %s: unique_id=%0d required %0d", name, bus.unique_id, exp_uid);
    end
    bus.alloc_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.alloc_req   = 1'b0;
    bus.alloc_in_id = 4'h0;
    bus.free_valid  = 1'b0;
    bus.free_uid    = 4'h0;
    bus.lookup_uid  = 4'h0;
    rst_n = 1'b0;
    #3;
    total++;
    if (bus.alloc_gnt !== 1'b0 || bus.unique_id !== 4'h0 || bus.tag_map_full !== 1'b0 ||
        outstanding_cnt !== 5'd0 || err_free !== 1'b0) begin
      bad++;
      $display("FAIL reset: gnt=%b uid=%0d full=%b cnt=%0d err=%b required 0 0 0 0 0",
               bus.alloc_gnt, bus.unique_id, bus.tag_map_full, outstanding_cnt, err_free);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_alloc();
    apply_reset();
    bus.alloc_req   = 1'b1;
    bus.alloc_in_id = 4'h7;
    bus.lookup_uid  = 4'h0;
    tick();
    total++;
    if (bus.alloc_gnt !== 1'b1 || bus.unique_id !== 4'h0 || outstanding_cnt !== 5'd1) begin
      bad++;
      $display("FAIL first_alloc: gnt=%b uid=%0d cnt=%0d required 1 0 1",
               bus.alloc_gnt, bus.unique_id, outstanding_cnt);
    end
    total++;
    if (bus.lookup_orig_id !== 4'h7) begin
      bad++;
      $display("FAIL first_lookup: orig=%h required 7", bus.lookup_orig_id);
    end
    bus.alloc_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < NUM_TAGS; i++) begin
      do_alloc(4'(15 - i), 4'(i), "b2b_uid");
    end
    total++;
    if (bus.tag_map_full !== 1'b1 || outstanding_cnt !== 5'd16) begin
      bad++;
      $display("FAIL b2b_full: full=%b cnt=%0d required 1 16", bus.tag_map_full, outstanding_cnt);
    end
    bus.lookup_uid = 4'd3;
    #1;
    total++;
    if (bus.lookup_orig_id !== 4'hC) begin
      bad++;
      $display("FAIL b2b_lookup: orig=%h required c", bus.lookup_orig_id);
    end
  endtask

  task automatic test_free_when_full();
    bus.alloc_req   = 1'b1;
    bus.alloc_in_id = 4'hA;
    tick();
    total++;
    if (bus.alloc_gnt !== 1'b0) begin
      bad++;
      $display("FAIL full_wait: gnt=%b required 0", bus.alloc_gnt);
    end
    bus.free_valid = 1'b1;
    bus.free_uid   = 4'd5;
    tick();
    bus.free_valid = 1'b0;
    total++;
    if (bus.tag_map_full !== 1'b0 || bus.alloc_gnt !== 1'b0 || outstanding_cnt !== 5'd15) begin
      bad++;
      $display("FAIL free_t1: full=%b gnt=%b cnt=%0d required 0 0 15",
               bus.tag_map_full, bus.alloc_gnt, outstanding_cnt);
    end
    tick();
    total++;
    if (bus.alloc_gnt !== 1'b1 || bus.unique_id !== 4'd5 || outstanding_cnt !== 5'd16) begin
      bad++;
      $display("FAIL free_t2: gnt=%b uid=%0d cnt=%0d required 1 5 16",
               bus.alloc_gnt, bus.unique_id, outstanding_cnt);
    end
    bus.alloc_req  = 1'b0;
    bus.lookup_uid = 4'd5;
    tick();
    total++;
    if (bus.lookup_orig_id !== 4'hA) begin
      bad++;
      $display("FAIL free_lookup: orig=%h required a", bus.lookup_orig_id);
    end
  endtask

  task automatic test_free_and_alloc();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_alloc(4'(i + 8), 4'(i), "fa_setup");
    end
    bus.alloc_req   = 1'b1;
    bus.alloc_in_id = 4'hE;
    bus.free_valid  = 1'b1;
    bus.free_uid    = 4'd2;
    tick();
    bus.free_valid = 1'b0;
    total++;
    if (bus.alloc_gnt !== 1'b1 || bus.unique_id !== 4'd4 || outstanding_cnt !== 5'd4) begin
      bad++;
      $display("FAIL same_cycle: gnt=%b uid=%0d cnt=%0d required 1 4 4",
               bus.alloc_gnt, bus.unique_id, outstanding_cnt);
    end
    bus.alloc_req = 1'b0;
    tick();
    do_alloc(4'h6, 4'd2, "reuse_2");
    bus.lookup_uid = 4'd2;
    #1;
    total++;
    if (bus.lookup_orig_id !== 4'h6 || outstanding_cnt !== 5'd5) begin
      bad++;
      $display("FAIL reuse_state: orig=%h cnt=%0d required 6 5", bus.lookup_orig_id, outstanding_cnt);
    end
  endtask

  task automatic test_illegal_free();
    logic exp_err;
`ifdef AR_TAG_MAP_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    total++;
    if (err_free !== 1'b0) begin
      bad++;
      $display("FAIL err_pre: err_free=%b required 0", err_free);
    end
    bus.free_valid = 1'b1;
    bus.free_uid   = 4'd9;
    tick();
    bus.free_valid = 1'b0;
    bus.lookup_uid = 4'd9;
    tick();
    total++;
    if (outstanding_cnt !== 5'd5 || bus.tag_map_full !== 1'b0 || bus.lookup_orig_id !== 4'h0) begin
      bad++;
      $display("FAIL illegal_free: cnt=%0d full=%b orig=%h required 5 0 0",
               outstanding_cnt, bus.tag_map_full, bus.lookup_orig_id);
    end
    total++;
    if (err_free !== exp_err) begin
      bad++;
      $display("FAIL err_free: err_free=%b required %b", err_free, exp_err);
    end
    do_alloc(4'h3, 4'd5, "after_illegal");
    // Retire entry 0 and confirm its recorded ID is still readable.
    bus.free_valid = 1'b1;
    bus.free_uid   = 4'd0;
    tick();
    bus.free_valid = 1'b0;
    bus.lookup_uid = 4'd0;
    #1;
    total++;
    if (bus.lookup_orig_id !== 4'h8 || outstanding_cnt !== 5'd5) begin
      bad++;
      $display("FAIL persist: orig=%h cnt=%0d required 8 5", bus.lookup_orig_id, outstanding_cnt);
    end
  endtask

  task automatic test_reset_mid_grant();
    bus.alloc_req   = 1'b1;
    bus.alloc_in_id = 4'h2;
    tick();
    total++;
    if (bus.alloc_gnt !== 1'b1 || bus.unique_id !== 4'd0) begin
      bad++;
      $display("FAIL pre_rst_grant: gnt=%b uid=%0d required 1 0", bus.alloc_gnt, bus.unique_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.alloc_gnt !== 1'b0 || bus.tag_map_full !== 1'b0 || outstanding_cnt !== 5'd0 ||
        err_free !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: gnt=%b full=%b cnt=%0d err=%b required 0 0 0 0",
               bus.alloc_gnt, bus.tag_map_full, outstanding_cnt, err_free);
    end
    bus.alloc_req = 1'b0;
    rst_n = 1'b1;
    tick();
    do_alloc(4'h9, 4'd0, "post_rst_uid");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    test_reset();
    test_first_alloc();
    test_back_to_back();
    test_free_when_full();
    test_free_and_alloc();
    test_illegal_free();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
